// File: rtl/cv32e41p_instr_obi_arbiter.sv
// Two-master round-robin arbiter for the instruction-side OBI port.
// Responses are routed back through an in-order FIFO of owner IDs.
module cv32e41p_instr_obi_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        obi_req_o,
  output logic [31:0] obi_addr_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,

  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_fifo [DEPTH];
  logic          r_rr;
  logic          r_lock;
  logic          r_lock_id;

  logic w_sel;
  logic w_req_sel;
  logic w_grant;
  logic w_pop;
  logic w_head;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves w_sel unassigned (no latch).
    w_sel = r_rr;
    if (r_lock) begin
      w_sel = r_lock_id;
    end else if (m0_req_i && !m1_req_i) begin
      w_sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      w_sel = 1'b1;
    end
  end

  assign w_req_sel  = w_sel ? m1_req_i : m0_req_i;
  assign obi_req_o  = !rst && w_req_sel && (r_cnt < FULL);
  assign obi_addr_o = (w_sel && !rst) ? m1_addr_i : m0_addr_i;

  assign w_grant  = obi_req_o && obi_gnt_i;
  assign m0_gnt_o = w_grant && !w_sel;
  assign m1_gnt_o = w_grant &&  w_sel;

  // A response with nothing outstanding (including the same-cycle grant) is dropped.
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = !rst && obi_rvalid_i && (r_cnt != '0);
  assign m0_rvalid_o = w_pop && !w_head;
  assign m1_rvalid_o = w_pop &&  w_head;
  assign m0_rdata_o  = obi_rdata_i;
  assign m1_rdata_o  = obi_rdata_i;
  assign m0_err_o    = obi_err_i;
  assign m1_err_o    = obi_err_i;

  assign busy_o = !rst && (obi_req_o || (r_cnt != '0));

  // NOTE: the owner storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_cnt     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      if (w_grant) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_grant) begin
        r_rr <= ~w_sel;
      end

      // Hold the pending request's owner until the memory accepts it.
      if (w_grant) begin
        r_lock <= 1'b0;
      end else if (obi_req_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end else begin
        r_lock <= 1'b0;
      end
    end
  end

  a_locked_req_stable: assert property (@(posedge clk) disable iff (rst) r_lock |-> w_req_sel)
    else $warning("a_locked_req_stable: locked master withdrew its request before grant");

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst) obi_rvalid_i |-> (r_cnt != '0))
    else $warning("a_no_spurious_rvalid: response with no outstanding transaction");

endmodule

// File: tb/tb_cv32e41p_instr_obi_arbiter.sv
// Directed bench for cv32e41p_instr_obi_arbiter (DEPTH=2).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_cv32e41p_instr_obi_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        obi_req_o;
  logic [31:0] obi_addr_o;
  logic        obi_gnt_i, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_rdata_i;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  cv32e41p_instr_obi_arbiter #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m0_gnt_o     (m0_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m0_err_o     (m0_err_o),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m1_gnt_o     (m1_gnt_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m1_rdata_o   (m1_rdata_o),
    .m1_err_o     (m1_err_o),
    .obi_req_o    (obi_req_o),
    .obi_addr_o   (obi_addr_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req_i     = 1'b0;
    m1_req_i     = 1'b0;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = '0;
    obi_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m0_addr_i = '0;
    m1_addr_i = '0;
    idle();

    // Reset: outputs forced low, address follows master 0.
    rst = 1'b1;
    m0_req_i = 1'b1; m1_req_i = 1'b1; m0_addr_i = 32'h123; m1_addr_i = 32'h456;
    obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1;
    settle();
    check("rst_obi_req",   obi_req_o,   0);
    check("rst_m0_gnt",    m0_gnt_o,    0);
    check("rst_m1_gnt",    m1_gnt_o,    0);
    check("rst_m0_rvalid", m0_rvalid_o, 0);
    check("rst_m1_rvalid", m1_rvalid_o, 0);
    check("rst_busy",      busy_o,      0);
    check("rst_addr",      obi_addr_o,  32'h123);
    tick();
    idle();
    tick();
    rst = 1'b0;
    settle();
    check("rst_cnt", dut.r_cnt, 0);
    check("rst_idle_busy", busy_o, 0);
    tick();

    // 1. Single master, back-to-back with one-cycle response latency.
    m0_req_i = 1'b1; m0_addr_i = 32'h100; obi_gnt_i = 1'b1;
    settle();
    check("t1_req0",  obi_req_o,  1);
    check("t1_addr0", obi_addr_o, 32'h100);
    check("t1_gnt0",  m0_gnt_o,   1);
    check("t1_m1gnt0", m1_gnt_o,  0);
    check("t1_busy0", busy_o,     1);
    tick();
    m0_addr_i = 32'h104; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hAAAA0001;
    settle();
    check("t1_addr1",   obi_addr_o,  32'h104);
    check("t1_gnt1",    m0_gnt_o,    1);
    check("t1_rv1",     m0_rvalid_o, 1);
    check("t1_rdata1",  m0_rdata_o,  32'hAAAA0001);
    check("t1_m1rv1",   m1_rvalid_o, 0);
    check("t1_cnt1",    dut.r_cnt,   1);
    tick();
    m0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rdata_i = 32'hAAAA0002; obi_err_i = 1'b1;
    settle();
    check("t1_rv2",     m0_rvalid_o, 1);
    check("t1_rdata2",  m0_rdata_o,  32'hAAAA0002);
    check("t1_err0",    m0_err_o,    1);
    check("t1_err1",    m1_err_o,    1);
    check("t1_m1rv2",   m1_rvalid_o, 0);
    check("t1_cnt2",    dut.r_cnt,   1);
    check("t1_req2",    obi_req_o,   0);
    check("t1_busy2",   busy_o,      1);
    tick();
    idle();
    settle();
    check("t1_busy3", busy_o, 0);
    tick();

    // 2. Fair alternation with a response every cycle after the first grant.
    do_reset();
    m0_req_i = 1'b1; m1_req_i = 1'b1; m0_addr_i = 32'h100; m1_addr_i = 32'h200; obi_gnt_i = 1'b1;
    settle();
    check("t2_addr0", obi_addr_o, 32'h100);
    check("t2_gnt0",  m0_gnt_o,   1);
    check("t2_gnt0b", m1_gnt_o,   0);
    tick();
    m0_addr_i = 32'h104; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hD0;
    settle();
    check("t2_addr1", obi_addr_o,  32'h200);
    check("t2_gnt1",  m1_gnt_o,    1);
    check("t2_rv1",   m0_rvalid_o, 1);
    check("t2_rv1b",  m1_rvalid_o, 0);
    tick();
    m1_addr_i = 32'h204; obi_rdata_i = 32'hD1;
    settle();
    check("t2_addr2", obi_addr_o,  32'h104);
    check("t2_gnt2",  m0_gnt_o,    1);
    check("t2_rv2",   m1_rvalid_o, 1);
    check("t2_rv2b",  m0_rvalid_o, 0);
    tick();
    obi_rdata_i = 32'hD2;
    settle();
    check("t2_addr3", obi_addr_o,  32'h204);
    check("t2_gnt3",  m1_gnt_o,    1);
    check("t2_rv3",   m0_rvalid_o, 1);
    tick();
    m0_req_i = 1'b0; m1_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rdata_i = 32'hD3;
    settle();
    check("t2_rv4",   m1_rvalid_o, 1);
    check("t2_rv4b",  m0_rvalid_o, 0);
    tick();
    idle();
    settle();
    check("t2_busy", busy_o, 0);
    tick();

    // 3. Lock: m1 stalls three cycles, m0 joins in cycle 2.
    do_reset();
    m1_req_i = 1'b1; m1_addr_i = 32'h200; m0_addr_i = 32'h100;
    settle();
    check("t3_c1_addr", obi_addr_o, 32'h200);
    check("t3_c1_req",  obi_req_o,  1);
    check("t3_c1_gnt",  m1_gnt_o,   0);
    tick();
    m0_req_i = 1'b1;
    settle();
    check("t3_c2_addr", obi_addr_o, 32'h200);
    check("t3_c2_gnt0", m0_gnt_o,   0);
    tick();
    settle();
    check("t3_c3_addr", obi_addr_o, 32'h200);
    tick();
    obi_gnt_i = 1'b1;
    settle();
    check("t3_c4_addr", obi_addr_o, 32'h200);
    check("t3_c4_gnt1", m1_gnt_o,   1);
    check("t3_c4_gnt0", m0_gnt_o,   0);
    tick();
    m1_req_i = 1'b0;
    settle();
    check("t3_c5_addr", obi_addr_o, 32'h100);
    check("t3_c5_gnt0", m0_gnt_o,   1);
    tick();
    m0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1;
    settle();
    check("t3_rv_m1", m1_rvalid_o, 1);
    tick();
    settle();
    check("t3_rv_m0", m0_rvalid_o, 1);
    tick();
    idle();

    // 4. Full at DEPTH=2; a response in the full cycle reopens issue next cycle.
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h100; obi_gnt_i = 1'b1;
    settle();
    check("t4_gnt_a", m0_gnt_o, 1);
    tick();
    m0_addr_i = 32'h104;
    settle();
    check("t4_gnt_b", m0_gnt_o, 1);
    tick();
    m0_addr_i = 32'h108;
    settle();
    check("t4_full_req",  obi_req_o, 0);
    check("t4_full_gnt",  m0_gnt_o,  0);
    check("t4_full_busy", busy_o,    1);
    tick();
    settle();
    check("t4_full_req2", obi_req_o, 0);
    tick();
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h55;
    settle();
    check("t4_rv",      m0_rvalid_o, 1);
    check("t4_rv_req",  obi_req_o,   0);
    tick();
    obi_rvalid_i = 1'b0;
    settle();
    check("t4_resume_req", obi_req_o, 1);
    check("t4_resume_gnt", m0_gnt_o,  1);
    tick();
    idle();

    // 6. Reset with two outstanding, then a stray response.
    settle();
    check("t6_pre_cnt", dut.r_cnt, 2);
    tick();
    rst = 1'b1;
    settle();
    check("t6_rst_busy", busy_o, 0);
    tick();
    rst = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD;
    settle();
    check("t6_cnt",  dut.r_cnt,   0);
    check("t6_rv0",  m0_rvalid_o, 0);
    check("t6_rv1",  m1_rvalid_o, 0);
    check("t6_busy", busy_o,      0);
    tick();
    idle();
    settle();
    check("t6_cnt_after", dut.r_cnt, 0);
    tick();

    // 5. Grant and response in the same cycle at one outstanding.
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h100; obi_gnt_i = 1'b1;
    settle();
    check("t5_gnt0", m0_gnt_o, 1);
    tick();
    m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 32'h300; obi_rvalid_i = 1'b1;
    settle();
    check("t5_gnt1", m1_gnt_o,    1);
    check("t5_rv0",  m0_rvalid_o, 1);
    check("t5_rv0b", m1_rvalid_o, 0);
    tick();
    m1_req_i = 1'b0; obi_gnt_i = 1'b0;
    settle();
    check("t5_cnt",  dut.r_cnt,   1);
    check("t5_rv1",  m1_rvalid_o, 1);
    check("t5_rv1b", m0_rvalid_o, 0);
    tick();
    idle();
    settle();
    check("t5_busy", busy_o, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
